// File: rtl/mult_arbiter.sv
// ---------------------------------------------------------------------------
// mult_arbiter
//
// Shares a single shift-add multiplier (datapath plus start/ready sequencer)
// among N_REQ client blocks. A winner is chosen among the active requests,
// its operands are latched onto the datapath, and the sequencer is started.
// The arbiter then waits for ready, captures the product, and releases the
// sequencer back to its IDLE state. The winner gets a one-cycle done pulse
// with the product on 'result'.
//
// Multiplier handshake (the sequencer has no reset from this block):
//   sequencer IDLE    : start=1 begins a job
//   sequencer STOPPED : ready=1 is shown; start=1 returns it to IDLE
//
// Parameters:
//   N_REQ     number of requesters (2..8)
//   n         operand width, equal to the multiplier's width
//   FLUSH_CYC cycles spent after reset letting an in-flight job drain
//
// Ports:
//   clock        in   system clock, rising edge
//   n_reset      in   asynchronous active-low reset
//   req          in   per-requester request level
//   a_in, b_in   in   packed operands, slice i belongs to requester i
//   gnt          out  one-hot pulse: operands of requester i captured
//   done         out  one-hot pulse: result valid for requester i
//   result       out  product of the last completed job
//   busy         out  high in every state except IDLE
//   mult_start   out  start line to the multiplier sequencer
//   mult_a/b     out  latched operands to the multiplier datapath
//   mult_ready   in   ready line from the multiplier sequencer
//   mult_product in   product from the multiplier datapath
//
// Build option:
//   MULT_ARB_FIXED_PRIO_EN  when defined, the lowest-index request always
//                           wins and no rotating pointer is kept. When not
//                           defined, requests are served round-robin.
// ---------------------------------------------------------------------------
module mult_arbiter #(
    parameter int N_REQ     = 4,
    parameter int n         = 4,
    parameter int FLUSH_CYC = 2*n+2
) (
    input  logic                 clock,
    input  logic                 n_reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*n-1:0]   a_in,
    input  logic [N_REQ*n-1:0]   b_in,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic [2*n-1:0]       result,
    output logic                 busy,
    output logic                 mult_start,
    output logic [n-1:0]         mult_a,
    output logic [n-1:0]         mult_b,
    input  logic                 mult_ready,
    input  logic [2*n-1:0]       mult_product
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(FLUSH_CYC + 1);
    localparam logic [CW-1:0]    FLUSH_LAST = CW'(FLUSH_CYC - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0   = N_REQ'(1);

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RELEASE
    } state_t;

    state_t        state;
    logic [CW-1:0] flush_cnt;
    logic [PW-1:0] owner;

    logic          win_valid;
    logic [PW-1:0] win_idx;
    logic [n-1:0]  sel_a;
    logic [n-1:0]  sel_b;

`ifndef MULT_ARB_FIXED_PRIO_EN
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] cand;
`endif

    // Winner selection and operand mux for the current request vector.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        sel_a     = '0;
        sel_b     = '0;
`ifdef MULT_ARB_FIXED_PRIO_EN
        // Scan downwards so the lowest set index is the last one written.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[PW'(k)]) begin
                win_valid = 1'b1;
                win_idx   = PW'(k);
            end
        end
`else
        // Search starts just after the previous winner and wraps around, so
        // the most recently served requester has the lowest priority.
        cand = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = PW'((int'(rr_ptr) + k) % N_REQ);
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
`endif
        for (int k = 0; k < N_REQ; k++) begin
            if (PW'(k) == win_idx) begin
                sel_a = a_in[k*n +: n];
                sel_b = b_in[k*n +: n];
            end
        end
    end

    // Main sequencer. mult_start is driven one cycle after entering LAUNCH
    // or RELEASE, so it is seen by the multiplier on the following edge.
    // In the first IDLE cycle after RELEASE the multiplier is still showing
    // ready while it consumes our start pulse; that ready is not stale, so
    // it is ignored while mult_start is high. This allows back-to-back
    // grants without a dead cycle.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state      <= S_FLUSH;
            flush_cnt  <= '0;
            gnt        <= '0;
            done       <= '0;
            result     <= '0;
            busy       <= 1'b1;
            mult_start <= 1'b0;
            mult_a     <= '0;
            mult_b     <= '0;
            owner      <= '0;
`ifndef MULT_ARB_FIXED_PRIO_EN
            rr_ptr     <= PW'(N_REQ - 1);
`endif
        end else begin
            gnt        <= '0;
            done       <= '0;
            mult_start <= 1'b0;
            case (state)
                S_FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        if (mult_ready) begin
                            state <= S_RELEASE;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (mult_ready && !mult_start) begin
                        state <= S_RELEASE;
                        busy  <= 1'b1;
                    end else if (win_valid) begin
                        gnt    <= ONE_HOT0 << win_idx;
                        mult_a <= sel_a;
                        mult_b <= sel_b;
                        owner  <= win_idx;
`ifndef MULT_ARB_FIXED_PRIO_EN
                        rr_ptr <= win_idx;
`endif
                        state  <= S_LAUNCH;
                        busy   <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    mult_start <= 1'b1;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (mult_ready) begin
                        result <= mult_product;
                        done   <= ONE_HOT0 << owner;
                        state  <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    mult_start <= 1'b1;
                    state      <= S_IDLE;
                    busy       <= 1'b0;
                end
                default: begin
                    state     <= S_FLUSH;
                    flush_cnt <= '0;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mult_arbiter
//
// Self-checking bench for mult_arbiter (N_REQ=4, n=4). A behavioural model
// of the team shift-add sequencer sits on the multiplier side: a job runs
// for 2n cycles after start and then holds ready until the next start.
// Stimulus pushes the expected grant and result into a scoreboard. A
// monitor running on the falling edge pops and compares them on every gnt
// and done pulse, and it also checks the gnt-to-done latency.
// ---------------------------------------------------------------------------
module tb_mult_arbiter;

    localparam int NR = 4;
    localparam int NW = 4;

    logic              clock;
    logic              n_reset;
    logic [NR-1:0]     req;
    logic [NR*NW-1:0]  a_in;
    logic [NR*NW-1:0]  b_in;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     done;
    logic [2*NW-1:0]   result;
    logic              busy;
    logic              mult_start;
    logic [NW-1:0]     mult_a;
    logic [NW-1:0]     mult_b;
    logic              mult_ready;
    logic [2*NW-1:0]   mult_product;

    mult_arbiter #(.N_REQ(NR), .n(NW)) dut (
        .clock        (clock),
        .n_reset      (n_reset),
        .req          (req),
        .a_in         (a_in),
        .b_in         (b_in),
        .gnt          (gnt),
        .done         (done),
        .result       (result),
        .busy         (busy),
        .mult_start   (mult_start),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_ready   (mult_ready),
        .mult_product (mult_product)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Sequencer model: IDLE -> RUN (2n cycles) -> STOPPED -> IDLE.
    typedef enum logic [1:0] {M_IDLE, M_RUN, M_STOP} mstate_t;
    mstate_t         m_state = M_IDLE;
    int              m_cnt   = 0;
    logic [2*NW-1:0] m_prod  = '0;

    always @(posedge clock) begin
        case (m_state)
            M_IDLE: if (mult_start) begin
                m_state <= M_RUN;
                m_cnt   <= 0;
                m_prod  <= (2*NW)'(mult_a) * (2*NW)'(mult_b);
            end
            M_RUN: begin
                if (m_cnt == 2*NW-1) m_state <= M_STOP;
                else                 m_cnt   <= m_cnt + 1;
            end
            default: if (mult_start) m_state <= M_IDLE;
        endcase
    end
    assign mult_ready   = (m_state == M_STOP);
    assign mult_product = m_prod;

    // Scoreboard state
    typedef struct {
        int idx;
        int res;
        bit has_done;
    } exp_t;

    exp_t exp_gnt_q[$];
    exp_t exp_done_q[$];
    int   start_cycles[$];
    int   gnt_cycles[$];

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int gnt_cnt      = 0;
    int done_cnt     = 0;
    int last_gnt_cyc = 0;
    int last_done_cyc = 0;
    bit job_active   = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents gnt or done.
    always @(negedge clock) begin
        exp_t e;
        if (!n_reset) job_active = 1'b0;
        if (gnt != '0) begin
            gnt_cnt++;
            last_gnt_cyc = cyc;
            gnt_cycles.push_back(cyc);
            checkOutput("gnt_onehot", $countones(gnt), 1);
            checkOutput("gnt_no_overlap", int'(job_active), 0);
            job_active = 1'b1;
            checkOutput("gnt_expected", int'(exp_gnt_q.size() != 0), 1);
            if (exp_gnt_q.size() != 0) begin
                e = exp_gnt_q.pop_front();
                checkOutput("gnt_index", int'(gnt), 1 << e.idx);
                if (e.has_done) exp_done_q.push_back(e);
            end
        end
        if (done != '0) begin
            done_cnt++;
            last_done_cyc = cyc;
            job_active = 1'b0;
            checkOutput("done_latency", cyc - last_gnt_cyc, 2*NW+3);
            checkOutput("done_expected", int'(exp_done_q.size() != 0), 1);
            if (exp_done_q.size() != 0) begin
                e = exp_done_q.pop_front();
                checkOutput("done_index", int'(done), 1 << e.idx);
                checkOutput("result", int'(result), e.res);
            end
        end
        if (mult_start) start_cycles.push_back(cyc);
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic pushExpect(input int idx, input int res, input bit has_done);
        exp_t e;
        e.idx      = idx;
        e.res      = res;
        e.has_done = has_done;
        exp_gnt_q.push_back(e);
    endtask

    task automatic setOperands(input int idx, input int a, input int b);
        a_in[idx*NW +: NW] = NW'(a);
        b_in[idx*NW +: NW] = NW'(b);
    endtask

    task automatic applyStimulus(input int idx, input int a, input int b, input bit has_done);
        pushExpect(idx, a * b, has_done);
        setOperands(idx, a, b);
        req[idx] = 1'b1;
    endtask

    // Waits for the next grant and drops the request right after it.
    task automatic waitGrantDrop(input int idx);
        int base = gnt_cnt;
        int t = 0;
        while (gnt_cnt == base && t < 200) begin
            tick(1);
            t++;
        end
        req[idx] = 1'b0;
        checkOutput("grant_arrived", gnt_cnt - base, 1);
    endtask

    task automatic waitGrants(input int target);
        int t = 0;
        while (gnt_cnt < target && t < 400) begin
            tick(1);
            t++;
        end
        checkOutput("grants_arrived", gnt_cnt, target);
    endtask

    task automatic waitDone(input int target);
        int t = 0;
        while (done_cnt < target && t < 400) begin
            tick(1);
            t++;
        end
        checkOutput("done_arrived", done_cnt, target);
    endtask

    task automatic waitIdle(output int cnt);
        cnt = 0;
        while (busy && cnt < 100) begin
            tick(1);
            cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected finish by 100000");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int cnt;
        int base_done;
        int base_gnt;
        int t;

        n_reset = 1'b1;
        req     = '0;
        a_in    = '0;
        b_in    = '0;
        #1 n_reset = 1'b0;
        tick(2);

        // Reset state
        checkOutput("rst_gnt",        int'(gnt), 0);
        checkOutput("rst_done",       int'(done), 0);
        checkOutput("rst_result",     int'(result), 0);
        checkOutput("rst_busy",       int'(busy), 1);
        checkOutput("rst_mult_start", int'(mult_start), 0);
        checkOutput("rst_mult_a",     int'(mult_a), 0);
        checkOutput("rst_mult_b",     int'(mult_b), 0);

        // Reset release with the multiplier idle: 2n+2 flush cycles.
        start_cycles.delete();
        n_reset = 1'b1;
        waitIdle(cnt);
        checkOutput("flush_cycles", cnt, 2*NW+2);
        tick(5);
        checkOutput("idle_busy", int'(busy), 0);
        checkOutput("flush_no_start", start_cycles.size(), 0);

        // Single job: 3*5
        start_cycles.delete();
        gnt_cycles.delete();
        base_done = done_cnt;
        applyStimulus(0, 3, 5, 1'b1);
        waitGrantDrop(0);
        waitDone(base_done + 1);
        tick(3);
        checkOutput("t2_start_count", start_cycles.size(), 2);
        if (start_cycles.size() == 2 && gnt_cycles.size() == 1) begin
            checkOutput("t2_start_after_gnt",  start_cycles[0], gnt_cycles[0] + 1);
            checkOutput("t2_start_after_done", start_cycles[1], last_done_cyc + 1);
        end
        checkOutput("t2_mult_ready_low", int'(mult_ready), 0);
        checkOutput("t2_busy_low", int'(busy), 0);

        // All four requesting, operands 15: order 0,1,2,3,0
        n_reset = 1'b0;
        tick(2);
        n_reset = 1'b1;
        waitIdle(cnt);
        checkOutput("t3_flush_cycles", cnt, 2*NW+2);
        gnt_cycles.delete();
        base_gnt  = gnt_cnt;
        base_done = done_cnt;
        for (int i = 0; i < NR; i++) setOperands(i, 15, 15);
        pushExpect(0, 225, 1'b1);
        pushExpect(1, 225, 1'b1);
        pushExpect(2, 225, 1'b1);
        pushExpect(3, 225, 1'b1);
        pushExpect(0, 225, 1'b1);
        req = 4'b1111;
        waitGrants(base_gnt + 5);
        req = 4'b0000;
        waitDone(base_done + 5);
        checkOutput("t3_grant_count", gnt_cycles.size(), 5);
        for (int i = 1; i < gnt_cycles.size(); i++)
            checkOutput("t3_grant_spacing", gnt_cycles[i] - gnt_cycles[i-1], 2*NW+5);

        // Reset in WAIT with the multiplier running: the job is dropped.
        tick(3);
        applyStimulus(1, 9, 9, 1'b0);
        waitGrantDrop(1);
        tick(5);
        base_done = done_cnt;
        n_reset = 1'b0;
        tick(2);
        start_cycles.delete();
        n_reset = 1'b1;
        waitIdle(cnt);
        checkOutput("t4_flush_release_cycles", cnt, 2*NW+3);
        checkOutput("t4_release_start_count", start_cycles.size(), 1);
        checkOutput("t4_no_done", done_cnt, base_done);
        tick(2);
        checkOutput("t4_mult_ready_low", int'(mult_ready), 0);
        base_done = done_cnt;
        applyStimulus(2, 2, 7, 1'b1);
        waitGrantDrop(2);
        waitDone(base_done + 1);

        // Reset while the multiplier is STOPPED with ready high.
        tick(3);
        applyStimulus(3, 4, 4, 1'b0);
        waitGrantDrop(3);
        t = 0;
        while (!mult_ready && t < 100) begin
            tick(1);
            t++;
        end
        checkOutput("t5_ready_seen", int'(mult_ready), 1);
        base_done = done_cnt;
        n_reset = 1'b0;
        tick(2);
        checkOutput("t5_ready_held", int'(mult_ready), 1);
        start_cycles.delete();
        base_gnt = gnt_cnt;
        n_reset = 1'b1;
        waitIdle(cnt);
        checkOutput("t5_flush_release_cycles", cnt, 2*NW+3);
        checkOutput("t5_release_start_count", start_cycles.size(), 1);
        checkOutput("t5_no_grant_before_release", gnt_cnt, base_gnt);
        checkOutput("t5_no_done", done_cnt, base_done);
        tick(2);
        checkOutput("t5_mult_ready_low", int'(mult_ready), 0);
        base_done = done_cnt;
        applyStimulus(0, 4, 4, 1'b1);
        waitGrantDrop(0);
        waitDone(base_done + 1);

        // Requesters 1 and 3 held together.
        tick(3);
        setOperands(1, 6, 7);
        setOperands(3, 5, 3);
        base_gnt  = gnt_cnt;
        base_done = done_cnt;
`ifdef MULT_ARB_FIXED_PRIO_EN
        pushExpect(1, 42, 1'b1);
        pushExpect(1, 42, 1'b1);
        pushExpect(1, 42, 1'b1);
        pushExpect(1, 42, 1'b1);
`else
        pushExpect(1, 42, 1'b1);
        pushExpect(3, 15, 1'b1);
        pushExpect(1, 42, 1'b1);
        pushExpect(3, 15, 1'b1);
`endif
        req = 4'b1010;
        waitGrants(base_gnt + 4);
        req = 4'b0000;
        waitDone(base_done + 4);

        tick(5);
        checkOutput("gnt_queue_empty",  exp_gnt_q.size(), 0);
        checkOutput("done_queue_empty", exp_done_q.size(), 0);
        checkOutput("final_busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
